// File: rtl/mem_responder.sv
// Word-addressed RAM plus a small MMIO block (console FIFO, status, cycle counter)
// answering one request per cycle with registered read data.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        enable_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wvalue_i,
    output logic [31:0] rvalue_o,
    output logic        con_valid_o,
    output logic [7:0]  con_data_o,
    input  logic        con_ready_i,
    output logic        fault_o
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0]   DEPTH_W  = 32'(DEPTH_WORDS);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic ram;
        logic con_data;
        logic con_stat;
        logic cycle;
        logic unmapped;
    } dec_t;

    dec_t          dec;
    logic [31:0]   word_idx;
    logic [AW-1:0] ram_idx;
    logic          rd_req, wr_req;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow, empty, full;
    logic          push_req, push_ok, pop;
    logic [31:0]   cycle_q, mmio_rdata;
    logic          unused_addr_lsb;

    assign word_idx        = {6'b0, addr_i[27:2]};
    assign ram_idx         = addr_i[AW+1:2];
    assign unused_addr_lsb = ^addr_i[1:0];

    // Requests are gated by reset so nothing issued during reset leaves a trace.
    assign rd_req = enable_i && rstn_i && (wstrb_i == 4'b0000);
    assign wr_req = enable_i && rstn_i && (wstrb_i != 4'b0000);

    always_comb begin
        dec = '0;
        case (addr_i[31:28])
            4'h0: dec.ram = (word_idx < DEPTH_W);
            4'h1: begin
                case (word_idx)
                    32'd0:   dec.con_data = 1'b1;
                    32'd1:   dec.con_stat = 1'b1;
                    32'd2:   dec.cycle    = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
        dec.unmapped = !(dec.ram || dec.con_data || dec.con_stat || dec.cycle);
    end

    always_comb begin
        mmio_rdata = '0;
        if (dec.con_stat)
            mmio_rdata = {29'b0, overflow, full, empty};
        else if (dec.cycle)
            mmio_rdata = cycle_q;
    end

    // RAM contents are never reset.
    always_ff @(posedge clk_i) begin
        if (wr_req && dec.ram) begin
            for (int n = 0; n < 4; n++) begin
                if (wstrb_i[n])
                    mem[ram_idx][8*n +: 8] <= wvalue_i[8*n +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rvalue_o <= '0;
            fault_o  <= 1'b0;
        end else begin
            fault_o <= enable_i && dec.unmapped;
            if (rd_req) begin
                if (dec.ram)
                    rvalue_o <= mem[ram_idx];
                else if (dec.unmapped)
                    rvalue_o <= 32'hDEAD_BEEF;
                else
                    rvalue_o <= mmio_rdata;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i)
            cycle_q <= '0;
        else
            cycle_q <= cycle_q + 32'd1;
    end

    assign empty       = (count == '0);
    assign full        = (count == CNT_FULL);
    assign con_valid_o = rstn_i && !empty;
    assign con_data_o  = fifo_q[rd_ptr];
    assign pop         = con_valid_o && con_ready_i;
    assign push_req    = wr_req && dec.con_data && wstrb_i[0];
    // A pop frees the slot in the same edge, so a full FIFO still takes the push.
    assign push_ok     = push_req && (!full || pop);

    always_ff @(posedge clk_i) begin
        if (push_ok)
            fifo_q[wr_ptr] <= wvalue_i[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push_req && full && !pop)
                overflow <= 1'b1;
            else if (wr_req && dec.con_stat)
                overflow <= 1'b0;
        end
    end

endmodule
